// File: rtl/pcm_ctrl_pkg.sv
// pcm_ctrl_pkg: shared types and constants for the PCM playback controller.
//   pcm_state_e       - playback FSM state encoding
//   PCM_ADDR_W_DEF    - default flash byte-address width
//   PCM_SILENCE       - sample word driven when no audio data is available
//   swap_half_bytes() - byte swap inside each 16-bit half (big-endian PCM)
package pcm_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_HOLD  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_ABORT = 3'd4
  } pcm_state_e;

  localparam int PCM_ADDR_W_DEF = 24;

  localparam logic [31:0] PCM_SILENCE = 32'h0000_0000;

  // Swap the two bytes of each 16-bit channel, keeping the channel order.
  function automatic logic [31:0] swap_half_bytes(input logic [31:0] word);
    return {word[23:16], word[31:24], word[7:0], word[15:8]};
  endfunction

endpackage

// File: rtl/pcm_fifo.sv
// pcm_fifo: synchronous prefetch FIFO for 32-bit PCM words.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   flush         - empty the FIFO (dominates push/pop)
//   push, wdata   - write one word (accepted when not full, or when popping)
//   pop, rdata    - read one word; rdata shows the head word
//   count, empty  - occupancy and empty flag
// Push and pop in the same cycle are allowed. DEPTH must be a power of two.
module pcm_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Qualify push/pop against the current occupancy.
  always_comb begin
    do_pop_s  = pop && (count_r != CNT_ZERO);
    do_push_s = push && ((count_r != CNT_FULL) || do_pop_s);
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= CNT_ZERO;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Data storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push_s && !flush) mem_r[wr_ptr_r] <= wdata;
  end

  assign rdata = mem_r[rd_ptr_r];
  assign count = count_r;
  assign empty = (count_r == CNT_ZERO);

endmodule

// File: rtl/pcm_playback_ctrl.sv
// pcm_playback_ctrl: streams a PCM clip from SPI flash into a prefetch FIFO
// and hands one 32-bit sample {right, left} per S/PDIF request.
// Ports:
//   clk_i, rst_i                    - clock, synchronous active-high reset
//   start_i, stop_i, loop_i         - play / abort commands, loop-at-end enable
//   base_addr_i, length_i           - clip byte address and byte length
//   flash_valid_o/addr_o/ready_i/rdata_i - word read port to the flash reader
//   sample_req_i, sample_o          - sample handshake (1-cycle latency)
//   busy_o, underrun_o, done_o      - playing flag, underrun and clip-end pulses
// Build option: define PCMCTL_BYTESWAP_EN for big-endian PCM in flash.
module pcm_playback_ctrl
  import pcm_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = PCM_ADDR_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              loop_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W-1:0] length_i,
  output logic              flash_valid_o,
  output logic [ADDR_W-1:0] flash_addr_o,
  input  logic              flash_ready_i,
  input  logic [31:0]       flash_rdata_i,
  input  logic              sample_req_i,
  output logic [31:0]       sample_o,
  output logic              busy_o,
  output logic              underrun_o,
  output logic              done_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int WRD_W = ADDR_W - 2;
  localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  DEPTH_M1_C = CNT_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [ADDR_W-1:0] WORD_STEP  = ADDR_W'(4);
  localparam logic [WRD_W-1:0]  WRD_ONE    = WRD_W'(1);
  localparam logic [WRD_W-1:0]  WRD_ZERO   = WRD_W'(0);

  pcm_state_e        state_r;
  logic [ADDR_W-1:0] base_r;
  logic [ADDR_W-1:0] addr_r;
  logic [WRD_W-1:0]  words_r;
  logic [WRD_W-1:0]  remain_r;
  logic              valid_r;
  logic              busy_r;
  logic              done_r;
  logic              underrun_r;
  logic [31:0]       sample_r;

  logic [WRD_W-1:0]  len_words_s;
  logic              push_s;
  logic              pop_s;
  logic              flush_s;
  logic              fill_s;
  logic              last_word_s;
  logic [31:0]       push_data_s;
  logic [31:0]       fifo_rdata_s;
  logic [CNT_W-1:0]  fifo_count_s;
  logic              fifo_empty_s;
  logic              len_lsb_unused_s;

  // Byte-level length bits carry no meaning: playback is word granular.
  assign len_lsb_unused_s = ^length_i[1:0];
  assign len_words_s      = length_i[ADDR_W-1:2];

`ifdef PCMCTL_BYTESWAP_EN
  assign push_data_s = swap_half_bytes(flash_rdata_i);
`else
  assign push_data_s = flash_rdata_i;
`endif

  // FIFO control: push only completed, non-aborted reads; flush on stop
  // and when an abandoned read finally completes.
  always_comb begin
    push_s  = 1'b0;
    flush_s = 1'b0;
    pop_s   = sample_req_i && !fifo_empty_s;
    case (state_r)
      ST_FETCH: begin
        push_s  = flash_ready_i && !stop_i;
        flush_s = stop_i;
      end
      ST_HOLD, ST_DRAIN: begin
        flush_s = stop_i;
      end
      ST_ABORT: begin
        flush_s = flash_ready_i;
      end
      default: begin
        push_s  = 1'b0;
        flush_s = 1'b0;
      end
    endcase
  end

  // Occupancy after this cycle's push equals the depth; a same-cycle pop
  // frees one slot, so the test shifts by one.
  always_comb begin
    if (pop_s) begin
      fill_s = (fifo_count_s == DEPTH_C);
    end else begin
      fill_s = (fifo_count_s == DEPTH_M1_C);
    end
    last_word_s = (remain_r == WRD_ONE);
  end

  pcm_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .flush (flush_s),
    .push  (push_s),
    .wdata (push_data_s),
    .pop   (pop_s),
    .rdata (fifo_rdata_s),
    .count (fifo_count_s),
    .empty (fifo_empty_s)
  );

  // Playback FSM with registered flash request, busy and done outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r  <= ST_IDLE;
      base_r   <= {ADDR_W{1'b0}};
      addr_r   <= {ADDR_W{1'b0}};
      words_r  <= WRD_ZERO;
      remain_r <= WRD_ZERO;
      valid_r  <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start_i && !stop_i) begin
            if (len_words_s != WRD_ZERO) begin
              base_r   <= base_addr_i;
              addr_r   <= base_addr_i;
              words_r  <= len_words_s;
              remain_r <= len_words_s;
              state_r  <= ST_FETCH;
              valid_r  <= 1'b1;
              busy_r   <= 1'b1;
            end else begin
              // Empty clip: report completion without touching flash.
              done_r <= 1'b1;
            end
          end
        end
        ST_FETCH: begin
          if (stop_i) begin
            if (flash_ready_i) begin
              // The read completes right now; drop it and stop cleanly.
              state_r <= ST_IDLE;
              valid_r <= 1'b0;
              busy_r  <= 1'b0;
            end else begin
              state_r <= ST_ABORT;
            end
          end else if (flash_ready_i) begin
            if (last_word_s && !loop_i) begin
              remain_r <= remain_r - WRD_ONE;
              state_r  <= ST_DRAIN;
              valid_r  <= 1'b0;
            end else begin
              if (last_word_s) begin
                // Seamless wrap: next read is the clip start.
                addr_r   <= base_r;
                remain_r <= words_r;
              end else begin
                addr_r   <= addr_r + WORD_STEP;
                remain_r <= remain_r - WRD_ONE;
              end
              if (fill_s) begin
                state_r <= ST_HOLD;
                valid_r <= 1'b0;
              end else begin
                state_r <= ST_FETCH;
                valid_r <= 1'b1;
              end
            end
          end
        end
        ST_HOLD: begin
          if (stop_i) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else if (fifo_count_s < DEPTH_C) begin
            state_r <= ST_FETCH;
            valid_r <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (stop_i) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else if (pop_s && (fifo_count_s == CNT_ONE)) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end
        end
        ST_ABORT: begin
          // The flash reader must see the request through to ready.
          if (flash_ready_i) begin
            state_r <= ST_IDLE;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Sample output register and underrun pulse; an empty FIFO yields silence.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sample_r   <= PCM_SILENCE;
      underrun_r <= 1'b0;
    end else begin
      underrun_r <= 1'b0;
      if (pop_s) begin
        sample_r <= fifo_rdata_s;
      end else if (sample_req_i) begin
        sample_r   <= PCM_SILENCE;
        underrun_r <= busy_r && (state_r != ST_DRAIN);
      end
    end
  end

  assign flash_valid_o = valid_r;
  assign flash_addr_o  = addr_r;
  assign sample_o      = sample_r;
  assign busy_o        = busy_r;
  assign underrun_o    = underrun_r;
  assign done_o        = done_r;

endmodule

// File: tb/tb_pcm_playback_ctrl.sv
`timescale 1ns/1ps
module tb_pcm_playback_ctrl;

  localparam int AW = 24;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          start_i = 1'b0;
  logic          stop_i = 1'b0;
  logic          loop_i = 1'b0;
  logic [AW-1:0] base_addr_i = '0;
  logic [AW-1:0] length_i = '0;
  logic          flash_valid_o;
  logic [AW-1:0] flash_addr_o;
  logic          flash_ready_i = 1'b0;
  logic [31:0]   flash_rdata_i = '0;
  logic          sample_req_i = 1'b0;
  logic [31:0]   sample_o;
  logic          busy_o;
  logic          underrun_o;
  logic          done_o;

  always #5 clk_i = ~clk_i;

  pcm_playback_ctrl #(.FIFO_DEPTH(4), .ADDR_W(AW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stop_i(stop_i),
    .loop_i(loop_i), .base_addr_i(base_addr_i), .length_i(length_i),
    .flash_valid_o(flash_valid_o), .flash_addr_o(flash_addr_o),
    .flash_ready_i(flash_ready_i), .flash_rdata_i(flash_rdata_i),
    .sample_req_i(sample_req_i), .sample_o(sample_o), .busy_o(busy_o),
    .underrun_o(underrun_o), .done_o(done_o)
  );

  int total = 0;
  int bad = 0;

  // flash responder
  int          flash_lat = 1;
  bit          flash_hold = 1'b0;
  bit          use_ovr = 1'b0;
  logic [31:0] ovr_data = 32'h0;
  int          wait_cnt = 0;

  // observation
  logic [AW-1:0] rd_log[$];
  int done_cnt = 0;
  int und_cnt = 0;

  // reference model: a clip is a list of words base+4k (mod 2^AW); fetched
  // words queue up, requests take from the front, silence when none.
  logic [31:0]   mq[$];
  bit            m_busy = 1'b0, m_drain = 1'b0, m_abort = 1'b0;
  logic [AW-1:0] m_addr = '0, m_base = '0;
  int            m_words = 0, m_fetched = 0;
  logic [31:0]   exp_sample = 32'h0;
  bit            exp_und = 1'b0, exp_done = 1'b0;

  function automatic logic [31:0] data_of(input logic [AW-1:0] a);
    return {~a[7:0], a};
  endfunction

  function automatic logic [31:0] expect_word(input logic [31:0] raw);
`ifdef PCMCTL_BYTESWAP_EN
    return ((raw & 32'h00FF00FF) << 8) | ((raw >> 8) & 32'h00FF00FF);
`else
    return raw;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: flash response and model update before the edge, output check after.
  task automatic cycle();
    bit h, was_busy;
    int w;
    if (rst_i) wait_cnt = 0;
    else if (flash_valid_o) wait_cnt++;
    flash_ready_i = flash_valid_o && !flash_hold && (wait_cnt >= flash_lat);
    flash_rdata_i = use_ovr ? ovr_data : data_of(flash_addr_o);
    h = flash_valid_o && flash_ready_i && !rst_i;
    if (h) wait_cnt = 0;
    exp_und = 1'b0;
    exp_done = 1'b0;
    if (rst_i) begin
      mq.delete();
      m_busy = 1'b0; m_drain = 1'b0; m_abort = 1'b0;
      exp_sample = 32'h0;
    end else begin
      was_busy = m_busy;
      if (flash_valid_o) chk("read_allowed", 32'(m_busy && !m_drain), 32'd1);
      if (sample_req_i) begin
        if (mq.size() != 0) begin
          exp_sample = mq.pop_front();
          if (m_drain && mq.size() == 0) begin
            m_busy = 1'b0; m_drain = 1'b0; exp_done = 1'b1;
          end
        end else begin
          exp_sample = 32'h0;
          if (m_busy && !m_drain) exp_und = 1'b1;
        end
      end
      if (m_abort) begin
        if (h) begin m_abort = 1'b0; m_busy = 1'b0; end
      end else if (stop_i && was_busy) begin
        mq.delete();
        m_drain = 1'b0;
        if (flash_valid_o && !h) m_abort = 1'b1;
        else m_busy = 1'b0;
      end else if (h) begin
        chk("rd_addr", 32'(flash_addr_o), 32'(m_addr));
        rd_log.push_back(flash_addr_o);
        mq.push_back(expect_word(flash_rdata_i));
        m_fetched++;
        if (m_fetched == m_words) begin
          if (loop_i) begin m_fetched = 0; m_addr = m_base; end
          else m_drain = 1'b1;
        end else begin
          m_addr = m_addr + 24'd4;
        end
      end
      if (start_i && !stop_i && !was_busy) begin
        w = int'(length_i >> 2);
        if (w == 0) exp_done = 1'b1;
        else begin
          m_busy = 1'b1; m_base = base_addr_i; m_addr = base_addr_i;
          m_words = w; m_fetched = 0; m_drain = 1'b0;
        end
      end
    end
    @(posedge clk_i);
    @(negedge clk_i);
    chk("sample_o", sample_o, exp_sample);
    chk("underrun_o", 32'(underrun_o), 32'(exp_und));
    chk("done_o", 32'(done_o), 32'(exp_done));
    chk("busy_o", 32'(busy_o), 32'(m_busy));
    if (rst_i) begin
      chk("rst_valid", 32'(flash_valid_o), 32'd0);
      chk("rst_addr", 32'(flash_addr_o), 32'd0);
    end
    if (done_o) done_cnt++;
    if (underrun_o) und_cnt++;
    start_i = 1'b0;
    stop_i = 1'b0;
    sample_req_i = 1'b0;
  endtask

  task automatic start_clip(input logic [AW-1:0] b, input logic [AW-1:0] l, input bit lp);
    base_addr_i = b;
    length_i = l;
    loop_i = lp;
    start_i = 1'b1;
    cycle();
  endtask

  task automatic wait_idle(input int budget);
    for (int c = 0; c < budget && m_busy; c++) begin
      sample_req_i = 1'b1;
      cycle();
    end
    chk("idle_reached", 32'(busy_o), 32'd0);
  endtask

  typedef struct {
    logic [AW-1:0] base;
    logic [AW-1:0] len;
    int            lat;
    int            exp_reads;
    logic [AW-1:0] exp_first;
    logic [AW-1:0] exp_last;
  } vec_t;

  vec_t vt[6];
  bit got;
  bit lp;

  initial begin
    vt[0] = '{24'h000000, 24'd16, 3, 4, 24'h000000, 24'h00000C};
    vt[1] = '{24'h000100, 24'd7,  1, 1, 24'h000100, 24'h000100};
    vt[2] = '{24'h000040, 24'd3,  2, 0, 24'h000000, 24'h000000};
    vt[3] = '{24'hFFFFF8, 24'd16, 2, 4, 24'hFFFFF8, 24'h000004};
    vt[4] = '{24'h000200, 24'd26, 1, 6, 24'h000200, 24'h000214};
    vt[5] = '{24'h000300, 24'd0,  1, 0, 24'h000000, 24'h000000};

    @(negedge clk_i);
    rst_i = 1'b1;
    cycle();
    cycle();
    rst_i = 1'b0;
    cycle();

    // table-driven single-shot clips
    foreach (vt[i]) begin
      flash_lat = vt[i].lat;
      rd_log.delete();
      done_cnt = 0;
      start_clip(vt[i].base, vt[i].len, 1'b0);
      for (int c = 0; c < 200 && (m_busy || c < 2); c++) begin
        sample_req_i = c[0];
        cycle();
      end
      chk("vec_idle", 32'(busy_o), 32'd0);
      chk("vec_reads", rd_log.size(), vt[i].exp_reads);
      if (vt[i].exp_reads > 0) begin
        chk("vec_first", 32'(rd_log[0]), 32'(vt[i].exp_first));
        chk("vec_last", 32'(rd_log[rd_log.size()-1]), 32'(vt[i].exp_last));
      end
      chk("vec_done_cnt", done_cnt, 1);
    end

    // looping clip: addresses keep alternating, no done
    flash_lat = 1;
    rd_log.delete();
    done_cnt = 0;
    start_clip(24'h000000, 24'd8, 1'b1);
    for (int c = 0; c < 24; c++) begin
      sample_req_i = 1'b1;
      cycle();
    end
    chk("loop_reads", 32'(rd_log.size() >= 6), 32'd1);
    for (int k = 0; k < 6 && k < rd_log.size(); k++)
      chk("loop_addr", 32'(rd_log[k]), 32'((k % 2) * 4));
    chk("loop_no_done", done_cnt, 0);
    stop_i = 1'b1;
    cycle();
    loop_i = 1'b0;
    wait_idle(20);

    // stalled flash: two requests underrun, then stop with read outstanding
    flash_hold = 1'b1;
    und_cnt = 0;
    done_cnt = 0;
    start_clip(24'h000080, 24'd16, 1'b0);
    cycle();
    sample_req_i = 1'b1; cycle();
    cycle();
    sample_req_i = 1'b1; cycle();
    cycle();
    chk("underrun_cnt", und_cnt, 2);
    chk("underrun_sample", sample_o, 32'h0);
    stop_i = 1'b1;
    cycle();
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("abort_valid_held", 32'(flash_valid_o), 32'd1);
    end
    flash_hold = 1'b0;
    for (int c = 0; c < 10 && m_busy; c++) cycle();
    chk("abort_idle", 32'(busy_o), 32'd0);
    chk("abort_no_done", done_cnt, 0);
    sample_req_i = 1'b1;
    cycle();
    chk("abort_fifo_empty", sample_o, 32'h0);

    // full FIFO parks in HOLD, one pop re-arms the read
    flash_lat = 1;
    start_clip(24'h000400, 24'd64, 1'b0);
    repeat (12) cycle();
    chk("hold_valid_low", 32'(flash_valid_o), 32'd0);
    chk("hold_busy", 32'(busy_o), 32'd1);
    sample_req_i = 1'b1;
    cycle();
    got = 1'b0;
    for (int k = 0; k < 2 && !got; k++) begin
      cycle();
      if (flash_valid_o) got = 1'b1;
    end
    chk("hold_refetch", 32'(got), 32'd1);
    stop_i = 1'b1;
    cycle();
    wait_idle(20);

    // channel byte order
    use_ovr = 1'b1;
    ovr_data = 32'h11223344;
    start_clip(24'h000000, 24'd4, 1'b0);
    repeat (4) cycle();
    sample_req_i = 1'b1;
    cycle();
`ifdef PCMCTL_BYTESWAP_EN
    chk("byte_order", sample_o, 32'h22114433);
`else
    chk("byte_order", sample_o, 32'h11223344);
`endif
    use_ovr = 1'b0;
    wait_idle(20);

    // reset in the middle of an outstanding read
    flash_hold = 1'b1;
    start_clip(24'h000010, 24'd32, 1'b0);
    repeat (3) cycle();
    chk("midread_valid", 32'(flash_valid_o), 32'd1);
    rst_i = 1'b1;
    cycle();
    rst_i = 1'b0;
    flash_hold = 1'b0;
    chk("midread_busy", 32'(busy_o), 32'd0);
    cycle();

    // randomized clips against the model
    for (int n = 0; n < 40; n++) begin
      flash_lat = $urandom_range(1, 4);
      lp = ($urandom_range(0, 3) == 0);
      start_clip(($urandom_range(0, 3) == 0) ? (24'hFFFFE0 + 24'($urandom_range(0, 7) * 4))
                                              : 24'($urandom),
                 24'($urandom_range(0, 48)), lp);
      for (int c = 0; c < 150 && m_busy; c++) begin
        sample_req_i = ($urandom_range(0, 2) == 0);
        if ($urandom_range(0, 15) == 0) begin
          start_i = 1'b1;
          base_addr_i = 24'($urandom);
          length_i = 24'($urandom_range(0, 64));
        end
        loop_i = lp ? ($urandom_range(0, 7) != 0) : 1'b0;
        if ($urandom_range(0, 99) == 0) begin
          stop_i = 1'b1;
          sample_req_i = 1'b0;
        end
        cycle();
      end
      if (m_busy) begin
        stop_i = 1'b1;
        cycle();
      end
      loop_i = 1'b0;
      wait_idle(50);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
